// File: rtl/vmul_pkg.sv
// Shared types and constants for the vmul round-robin scheduler slice.
package vmul_pkg;

  localparam int unsigned OPW   = 8;
  localparam int unsigned PRODW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/vmul_rr_sched_if.sv
// Request/response bus between DSP clients and the shared multiplier scheduler.
interface vmul_rr_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_q;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, busy
  );
endinterface

// File: rtl/v8_bka.sv
// 8x8 unsigned Vedic multiplier: crosswise 4x4 partial products summed by Brent-Kung adders.
module V8_BKA
  import vmul_pkg::*;
(
  input  logic [OPW-1:0]   i_a,
  input  logic [OPW-1:0]   i_b,
  output logic [PRODW-1:0] o_p
);

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] xx;
    logic [7:0] yy;
    xx = {4'd0, x};
    yy = {4'd0, y};
    return xx * yy;
  endfunction

  // Brent-Kung parallel prefix: up-sweep builds group carries, down-sweep fills the gaps.
  function automatic logic [15:0] bka_add16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p;
    logic [15:0] gg;
    logic [15:0] pp;
    logic [15:0] s;
    p  = x ^ y;
    gg = x & y;
    pp = p;
    for (int d = 1; d < 16; d = d * 2) begin
      for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    s[0] = p[0];
    for (int i = 1; i < 16; i++) s[i] = p[i] ^ gg[i-1];
    return s;
  endfunction

  logic [7:0]       w_ll, w_lh, w_hl, w_hh;
  logic [PRODW-1:0] w_mid, w_sum1;

  assign w_ll   = mul4(i_a[3:0], i_b[3:0]);
  assign w_lh   = mul4(i_a[3:0], i_b[7:4]);
  assign w_hl   = mul4(i_a[7:4], i_b[3:0]);
  assign w_hh   = mul4(i_a[7:4], i_b[7:4]);
  assign w_mid  = bka_add16(PRODW'(w_lh), PRODW'(w_hl));
  assign w_sum1 = bka_add16(PRODW'(w_ll), w_mid << 4);
  assign o_p    = bka_add16(w_sum1, PRODW'(w_hh) << 8);

endmodule

// File: rtl/vmul_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module vmul_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt_onehot,
  output logic [ID_W-1:0]  o_gnt_idx,
  output logic             o_any
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_any        = 1'b0;
    w_cand       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'((32'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any        = 1'b1;
        o_gnt_idx    = w_cand;
        o_gnt_onehot = N_REQ'(1) << w_cand;
      end
    end
  end

endmodule

// File: rtl/vmul_rr_sched.sv
// Round-robin scheduler sharing one V8_BKA multiplier among N_REQ requesters.
// Optional grant counters under macro VMUL_SCHED_PERF_EN.
module vmul_rr_sched
  import vmul_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  vmul_rr_sched_if.slave     bus
`ifdef VMUL_SCHED_PERF_EN
  ,
  input  logic               perf_clr,
  output logic [16*N_REQ-1:0] perf_cnt
`endif
);

  state_e           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, r_gid, r_rsp_id;
  logic [ID_W-1:0]  w_gnt_idx, w_ptr_nxt;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic             w_any, w_grant_win, w_take;
  logic [OPW-1:0]   r_op_a, r_op_b, w_sel_a, w_sel_b;
  logic [PRODW-1:0] w_prod, r_rsp_q;
  logic             r_rsp_valid;

  vmul_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req        (bus.req_valid),
    .i_ptr        (r_ptr),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  V8_BKA u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grants open in IDLE and in RESP once the consumer takes the product.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_win = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_win = 1'b1;
        if (w_any) w_state_nxt = MUL;
      end
      MUL:  w_state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          w_grant_win = 1'b1;
          w_state_nxt = w_any ? MUL : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_take        = w_grant_win & w_any & ~rst;
  assign bus.req_ready = w_take ? w_gnt_onehot : '0;
  assign w_ptr_nxt     = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt_onehot[i]) begin
        w_sel_a = bus.req_a[i*OPW +: OPW];
        w_sel_b = bus.req_b[i*OPW +: OPW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_gid       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
    end else begin
      if (w_take) begin
        r_op_a <= w_sel_a;
        r_op_b <= w_sel_b;
        r_gid  <= w_gnt_idx;
        r_ptr  <= w_ptr_nxt;
      end
      if (r_state == MUL) begin
        r_rsp_q     <= w_prod;
        r_rsp_id    <= r_gid;
        r_rsp_valid <= 1'b1;
      end else if (r_state == RESP && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.busy      = (r_state != IDLE);

`ifdef VMUL_SCHED_PERF_EN
  logic [15:0] r_perf_cnt [N_REQ];

  // Saturating per-requester grant counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) r_perf_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (perf_clr)
          r_perf_cnt[i] <= '0;
        else if (w_take && w_gnt_onehot[i] && r_perf_cnt[i] != 16'hFFFF)
          r_perf_cnt[i] <= r_perf_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    perf_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) perf_cnt[i*16 +: 16] = r_perf_cnt[i];
  end
`endif

endmodule

// File: tb/tb_vmul_rr_sched.sv
// Directed self-checking bench for vmul_rr_sched (optionally with VMUL_SCHED_PERF_EN).
module tb_vmul_rr_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_q;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  vmul_rr_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

`ifdef VMUL_SCHED_PERF_EN
  logic        perf_clr;
  logic [63:0] perf_cnt;
`endif

  vmul_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef VMUL_SCHED_PERF_EN
    ,
    .perf_clr (perf_clr),
    .perf_cnt (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full transaction for a lone requester, starting in IDLE right after a negedge.
  task automatic run_single(input int id, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_q);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    bus.req_valid = oh;
    bus.req_a[id*8 +: 8] = a;
    bus.req_b[id*8 +: 8] = b;
    #1 chk("single_grant", 32'(bus.req_ready), 32'(oh));
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("single_mul_busy", 32'(bus.busy), 32'd1);
    chk("single_mul_novalid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    #1 chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_rsp_q", 32'(bus.rsp_q), 32'(exp_q));
    chk("single_rsp_id", 32'(bus.rsp_id), 32'(id));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 chk("single_idle_valid", 32'(bus.rsp_valid), 32'd0);
    chk("single_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    logic [15:0] exp_q;
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{0, 8'd13,  8'd11,  16'd143};
    vecs[1] = '{1, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{2, 8'd0,   8'd200, 16'd0};
    vecs[3] = '{3, 8'd1,   8'hA5,  16'h00A5};
    vecs[4] = '{2, 8'd200, 8'd3,   16'd600};
    vecs[5] = '{1, 8'd17,  8'd15,  16'd255};
    vecs[6] = '{3, 8'd128, 8'd2,   16'd256};
    vecs[7] = '{0, 8'd255, 8'd1,   16'd255};

    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
`ifdef VMUL_SCHED_PERF_EN
    perf_clr = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_q", 32'(bus.rsp_q), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_q);

    // Reset while in MUL: the in-flight op vanishes and ptr returns to 0.
    bus.req_valid = 4'b0010;
    bus.req_a[15:8] = 8'd5;
    bus.req_b[15:8] = 8'd5;
    #1 chk("rstmul_grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    #1 chk("rstmul_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmul_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("rstmul_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'b1010;
    bus.req_a[31:24] = 8'd9;
    bus.req_b[31:24] = 8'd9;
    #1 chk("rstmul_lowest", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1 chk("rstmul_rsp_id", 32'(bus.rsp_id), 32'd1);
    chk("rstmul_rsp_q", 32'(bus.rsp_q), 32'd25);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All requesters valid, consumer always ready: grants 0,1,2,3,0 every 2 cycles.
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*8 +: 8] = 8'(10 + i);
      bus.req_b[i*8 +: 8] = 8'(3 + i);
    end
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #1 chk("rr_first_grant", 32'(bus.req_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 chk("rr_mul_noready", 32'(bus.req_ready), 32'd0);
      chk("rr_mul_novalid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      exp_q = 16'((10 + k % 4) * (3 + k % 4));
      #1 chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rr_rsp_id", 32'(bus.rsp_id), 32'(k % 4));
      chk("rr_rsp_q", 32'(bus.rsp_q), 32'(exp_q));
      if (k < 4) begin
        chk("rr_b2b_grant", 32'(bus.req_ready), 32'(4'b0001 << ((k + 1) % 4)));
      end else begin
        bus.req_valid = '0;
        #1 chk("rr_last_noready", 32'(bus.req_ready), 32'd0);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 chk("rr_idle_busy", 32'(bus.busy), 32'd0);
    chk("rr_idle_valid", 32'(bus.rsp_valid), 32'd0);

    // Back-pressure: 5 stalled cycles in RESP, then grant on the cycle rsp_ready rises.
    bus.req_valid = 4'b0100;
    bus.req_a[23:16] = 8'd7;
    bus.req_b[23:16] = 8'd9;
    #1 chk("bp_grant", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    bus.req_a[31:24] = 8'd20;
    bus.req_b[31:24] = 8'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_q", 32'(bus.rsp_q), 32'd63);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd2);
      chk("bp_hold_noready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_grant", 32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("bp_mul_novalid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    #1 chk("bp_rsp_id", 32'(bus.rsp_id), 32'd3);
    chk("bp_rsp_q", 32'(bus.rsp_q), 32'd400);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 chk("bp_idle_busy", 32'(bus.busy), 32'd0);

`ifdef VMUL_SCHED_PERF_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("perf_rst", perf_cnt[31:0] | perf_cnt[63:32], 32'd0);
    for (int i = 0; i < 3; i++) run_single(2, 8'd3, 8'd4, 16'd12);
    chk("perf_req2", 32'(perf_cnt[47:32]), 32'd3);
    chk("perf_others", 32'(perf_cnt[31:0]) | 32'(perf_cnt[63:48]), 32'd0);
    perf_clr = 1'b1;
    bus.req_valid = 4'b0100;
    #1 chk("perf_clr_grant", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    perf_clr = 1'b0;
    bus.req_valid = '0;
    #1 chk("perf_clr_wins", 32'(perf_cnt[47:32]), 32'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 chk("perf_after_clr", 32'(perf_cnt[47:32]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
